pixel_offset_stream: RTL and testbench
======================================

Name: pixel_offset_stream

Overview:
- Streaming stage directly upstream of the 8-bit add/sub datapath's consumers. It performs the same pixel ± offset operation, but frame-sequenced, handshaked and saturating.
- Accepts one 8-bit grayscale pixel per cycle from the image input buffer. Adds or subtracts a frame-constant brightness offset, clamps to [0,255] and emits the result through a one-deep registered output slice.
- Counts pixels per frame, flags the last output pixel and reports how many pixels clamped, for readback by the MATLAB host link.

Parameters:
- FRAME_PIXELS, 16384, pixels per frame (128x128); must be >= 1.
- CNT_W, 14, pixel counter width; must satisfy 2^CNT_W >= FRAME_PIXELS.
- SATC_W, 16, width of the clamp counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a frame; ignored unless state is IDLE.
- cfg_offset  in  8  unsigned offset; sampled on an accepted start.
- cfg_opsel  in  1  0 = add, 1 = subtract; sampled on an accepted start.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input pixel accepted when s_valid & s_ready.
- s_data  in  8  input pixel, unsigned.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream ready.
- m_data  out  8  clamped result.
- m_last  out  1  high with the final pixel of the frame.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse when a frame fully drains.
- sat_count  out  SATC_W  clamped pixels in current/last frame; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE.
  - s_ready=0, m_valid=0, m_data=0, m_last=0, busy=0, frame_done=0, sat_count=0.
  - Offset/opsel registers=0, pixel counter=0.
- Reset mid-frame aborts immediately. Any held output is dropped and no frame_done is issued.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start. Latch cfg_offset/cfg_opsel, clear the pixel counter and sat_count.
  - RUN -> DRAIN on the cycle the FRAME_PIXELS-th input is accepted.
  - DRAIN -> IDLE when the output slice empties (m_valid & m_ready with m_last, or already empty). frame_done pulses in the same cycle the state returns to IDLE.
  - start in RUN/DRAIN is ignored; cfg changes outside an accepted start have no effect.
- Handshake:
  - s_ready = (state==RUN) & (~m_valid | m_ready). This is combinational and does not depend on s_valid.
  - The output slice loads on input acceptance. It holds m_data/m_last stable while m_valid & ~m_ready.
  - m_valid may not drop without m_ready.
  - Latency is 1 cycle from acceptance to m_valid. Full throughput is one pixel per cycle while m_ready=1.
  - Simultaneous output-consume and input-accept in one cycle replaces the slice contents with no bubble.
- Arithmetic, computed in 9 bits as {1'b0,A} + {1'b0,B^{8{op}}} + op:
  - Add: carry=1 -> result 255, clamp event.
  - Subtract: carry=0 (borrow) -> result 0, clamp event.
  - Otherwise the result is the low 8 bits.
  - Offset 0 never clamps.
- sat_count increments on each accepted input whose result clamped. It holds at 2^SATC_W-1 and holds its value after the frame until the next accepted start.
- m_last is asserted on the output pixel corresponding to pixel counter == FRAME_PIXELS-1.
- The pixel counter wraps to 0 only via a new start; it never wraps mid-frame.
- Inputs presented while in IDLE/DRAIN are not accepted (s_ready=0).

Decomposition:
- Shared package pixel_pkg:
  - PIX_W=8, PIX_MAX=8'hFF, PIX_MIN=8'h00.
  - State enum {IDLE, RUN, DRAIN}.
  - OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module, sat_add_sub8. Purely combinational; inputs a, b, opsel; outputs result, clamp. It uses the carry-in=opsel / XOR-B structure plus a carry-out-based clamp. The top level holds the FSM, counters and output slice.

Test Plan:
- Add with no clamp: start with offset=8'd20, op=0, FRAME_PIXELS=4, pixels 10,100,200,235 with m_ready=1 -> m_data 30,120,220,255; m_last on the 4th; sat_count=0; frame_done one cycle after the last handshake.
- Add with clamp: offset=8'd100, op=0, pixels 0,155,156,255 -> 100,255,255,255; sat_count=2.
- Subtract with clamp: offset=8'd50, op=1, pixels 49,50,51,255 -> 0,0,1,205; sat_count=1.
- Backpressure: m_ready held 0 for 3 cycles mid-frame -> s_ready=0 and m_data/m_valid stable. On release, no pixel is lost or duplicated and full throughput resumes.
- Protocol guards: start pulsed during RUN and config changed mid-frame -> ignored, with results still using the latched offset. s_valid during IDLE -> s_ready=0 and no output.
- Async reset: rst_n=0 mid-frame with m_valid=1 -> all outputs reset immediately and no frame_done. A subsequent start runs a clean frame with sat_count restarting from 0.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel offset streaming stage.
package pixel_pkg;

    localparam int         PIX_W   = 8;
    localparam logic [7:0] PIX_MAX = 8'hFF;
    localparam logic [7:0] PIX_MIN = 8'h00;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sat_add_sub8.sv
// Saturating 8-bit add/subtract. Subtract is a + ~b + 1, so the 9th bit is a
// carry on add (overflow past 255) and a not-borrow on subtract (result < 0
// when it is clear).
module sat_add_sub8
    import pixel_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       opsel,
    output logic [7:0] result,
    output logic       clamp
);

    logic [8:0] sum;

    assign sum    = {1'b0, a} + {1'b0, b ^ {PIX_W{opsel}}} + {8'd0, opsel};
    assign clamp  = (opsel == OP_ADD) ? sum[8] : ~sum[8];
    assign result = clamp ? ((opsel == OP_ADD) ? PIX_MAX : PIX_MIN) : sum[7:0];

endmodule

// File: rtl/pixel_offset_stream.sv
// Frame-sequenced pixel +/- offset stage with a one-deep registered output
// slice, per-frame pixel counter, last-pixel flag and clamp counter.
module pixel_offset_stream
    import pixel_pkg::*;
#(
    parameter int FRAME_PIXELS = 16384,
    parameter int CNT_W        = 14,
    parameter int SATC_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        cfg_offset,
    input  logic              cfg_opsel,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        m_data,
    output logic              m_last,
    output logic              busy,
    output logic              frame_done,
    output logic [SATC_W-1:0] sat_count
);

    state_t           state, state_nx;
    logic [7:0]       off_q;
    logic             op_q;
    logic [CNT_W-1:0] pix_cnt;
    logic [7:0]       alu_res;
    logic             alu_clamp;
    logic             accept, consume, last_pix, start_acc, drain_done;

    // The slice can take a new pixel when empty or when it is being consumed
    // this cycle, which gives back-to-back throughput without a bubble.
    assign s_ready    = (state == RUN) & (~m_valid | m_ready);
    assign accept     = s_valid & s_ready;
    assign consume    = m_valid & m_ready;
    assign last_pix   = (pix_cnt == CNT_W'(FRAME_PIXELS - 1));
    assign start_acc  = start & (state == IDLE);
    assign drain_done = (state == DRAIN) & (~m_valid | (consume & m_last));
    assign busy       = (state != IDLE);

    sat_add_sub8 u_alu (
        .a      (s_data),
        .b      (off_q),
        .opsel  (op_q),
        .result (alu_res),
        .clamp  (alu_clamp)
    );

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)             state_nx = RUN;
            RUN:     if (accept & last_pix) state_nx = DRAIN;
            DRAIN:   if (drain_done)        state_nx = IDLE;
            default:                        state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Offset and operation are frame constants, captured only on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q <= 8'd0;
            op_q  <= OP_ADD;
        end else if (start_acc) begin
            off_q <= cfg_offset;
            op_q  <= cfg_opsel;
        end
    end

    // Pixel counter parks on the last index so it never wraps within a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  pix_cnt <= '0;
        else if (start_acc)          pix_cnt <= '0;
        else if (accept & ~last_pix) pix_cnt <= pix_cnt + CNT_W'(1);
    end

    // Clamp counter: saturates at all-ones and holds until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                sat_count <= '0;
        else if (start_acc)                        sat_count <= '0;
        else if (accept & alu_clamp & ~&sat_count) sat_count <= sat_count + SATC_W'(1);
    end

    // Output slice: loads on accept, empties on consume, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= 8'd0;
            m_last  <= 1'b0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_data  <= alu_res;
            m_last  <= last_pix;
        end else if (consume) begin
            m_valid <= 1'b0;
        end
    end

    // frame_done is registered so it coincides with the first IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_done <= 1'b0;
        else        frame_done <= drain_done;
    end

endmodule

// File: tb/tb_pixel_offset_stream.sv
// Directed bench for pixel_offset_stream with a transaction-level model
// (expected-output queue) checked every cycle plus literal frame results.
module tb_pixel_offset_stream;

    localparam int FP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cfg_offset = 8'd0;
    logic        cfg_opsel = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'd0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [7:0]  m_data;
    logic        m_last;
    logic        busy;
    logic        frame_done;
    logic [15:0] sat_count;

    pixel_offset_stream #(.FRAME_PIXELS(FP), .CNT_W(14), .SATC_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_offset(cfg_offset),
        .cfg_opsel(cfg_opsel), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy), .frame_done(frame_done), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mstate: 0 idle, 1 taking pixels, 2 waiting for the last output to leave
    int  mstate = 0;
    int  mcnt = 0;
    int  msat = 0;
    int  moff = 0;
    bit  mop = 0;
    bit  mfd = 0;
    int  q_data[$];
    bit  q_last[$];
    int  seen[$];

    function automatic int exp_pix(input int p, input int off, input bit op);
        if (!op) return (p + off > 255) ? 255 : p + off;
        else     return (p < off) ? 0 : p - off;
    endfunction

    function automatic bit exp_clamp(input int p, input int off, input bit op);
        if (!op) return (p + off > 255);
        else     return (p < off);
    endfunction

    // Compare DUT against the model, then advance the model to the next edge.
    always @(negedge clk) begin
        bit had, acc, fd_n;
        if (!rst_n) begin
            mstate = 0; mcnt = 0; msat = 0; moff = 0; mop = 0; mfd = 0;
            q_data.delete(); q_last.delete();
        end
        chk("busy", busy, 32'(mstate != 0));
        chk("frame_done", frame_done, 32'(mfd));
        chk("sat_count", sat_count, msat);
        chk("m_valid", m_valid, 32'(q_data.size() != 0));
        chk("s_ready", s_ready, 32'(mstate == 1 && (q_data.size() == 0 || m_ready)));
        if (q_data.size() != 0) begin
            chk("m_data", m_data, q_data[0]);
            chk("m_last", m_last, 32'(q_last[0]));
        end
        if (rst_n) begin
            fd_n = 0;
            had  = (q_data.size() != 0);
            acc  = (mstate == 1) && s_valid && (!had || m_ready);
            if (had && m_ready) begin
                seen.push_back(int'(m_data));
                void'(q_data.pop_front());
                void'(q_last.pop_front());
            end
            case (mstate)
                0: if (start) begin
                       mstate = 1; moff = int'(cfg_offset); mop = cfg_opsel;
                       mcnt = 0; msat = 0;
                   end
                1: if (acc) begin
                       q_data.push_back(exp_pix(int'(s_data), moff, mop));
                       q_last.push_back(mcnt == FP - 1);
                       if (exp_clamp(int'(s_data), moff, mop) && msat < 65535) msat++;
                       mcnt++;
                       if (mcnt == FP) mstate = 2;
                   end
                default: if (q_data.size() == 0) begin mstate = 0; fd_n = 1; end
            endcase
            mfd = fd_n;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_start(input int off, input bit op);
        cfg_offset = 8'(off); cfg_opsel = op; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Present a pixel and hold it until accepted; s_valid stays high afterwards
    // so consecutive calls stream at full rate.
    task automatic send(input int p);
        bit ok = 0;
        s_valid = 1'b1; s_data = 8'(p);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = s_ready;
            step();
        end
        chk("send_accepted", 32'(ok), 1);
    endtask

    task automatic wait_done();
        bit ok = 0;
        s_valid = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = frame_done;
        end
        chk("frame_done_seen", 32'(ok), 1);
        step();
    endtask

    task automatic check_frame(input string name, input int e0, input int e1,
                               input int e2, input int e3, input int esat);
        chk({name, "_count"}, seen.size(), 4);
        if (seen.size() == 4) begin
            chk({name, "_px0"}, seen[0], e0);
            chk({name, "_px1"}, seen[1], e1);
            chk({name, "_px2"}, seen[2], e2);
            chk({name, "_px3"}, seen[3], e3);
        end
        chk({name, "_sat"}, sat_count, esat);
        seen.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(); step();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sat", sat_count, 0);
        rst_n = 1'b1; m_ready = 1'b1;
        step();

        // add, no clamp (235+20 lands exactly on 255)
        do_start(20, 0);
        send(10); send(100); send(200); send(235);
        wait_done();
        check_frame("add", 30, 120, 220, 255, 0);

        // add with clamp
        do_start(100, 0);
        send(0); send(155); send(156); send(255);
        wait_done();
        check_frame("addsat", 100, 255, 255, 255, 2);

        // subtract with clamp (50-50 is exactly 0, not a clamp)
        do_start(50, 1);
        send(49); send(50); send(51); send(255);
        wait_done();
        check_frame("subsat", 0, 0, 1, 205, 1);

        // backpressure mid-frame
        do_start(20, 0);
        send(1); send(2);
        m_ready = 1'b0; s_valid = 1'b1; s_data = 8'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_s_ready", s_ready, 0);
            chk("bp_m_valid", m_valid, 1);
            chk("bp_m_data", m_data, 22);
            step();
        end
        m_ready = 1'b1;
        send(3); send(4);
        wait_done();
        check_frame("bp", 21, 22, 23, 24, 0);

        // start and config changes during RUN are ignored
        do_start(30, 0);
        send(5);
        start = 1'b1; cfg_offset = 8'd200; cfg_opsel = 1'b1;
        send(6);
        start = 1'b0;
        send(7); send(8);
        wait_done();
        check_frame("guard", 35, 36, 37, 38, 0);

        // input offered while idle is not taken
        s_valid = 1'b1; s_data = 8'd99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_s_ready", s_ready, 0);
            chk("idle_m_valid", m_valid, 0);
            step();
        end
        s_valid = 1'b0;
        seen.delete();

        // async reset with a held output
        m_ready = 1'b0;
        do_start(10, 0);
        send(7);
        s_valid = 1'b0;
        chk("pre_rst_m_valid", m_valid, 1);
        chk("pre_rst_m_data", m_data, 17);
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", m_valid, 0);
        chk("arst_m_data", m_data, 0);
        chk("arst_m_last", m_last, 0);
        chk("arst_busy", busy, 0);
        chk("arst_s_ready", s_ready, 0);
        chk("arst_frame_done", frame_done, 0);
        step(); step();
        rst_n = 1'b1; m_ready = 1'b1;
        step(); step(); step();
        seen.delete();

        // clean frame after reset (5+250 reaches 255 without clamping)
        do_start(250, 0);
        send(0); send(5); send(6); send(1);
        wait_done();
        check_frame("postrst", 250, 255, 255, 251, 1);

        step(); step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
